// File: rtl/inst_rom_loader_pkg.sv
// Shared types for the streaming instruction ROM loader.
// State codes and bus widths used by inst_rom_loader and its memory.
package inst_rom_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LEN_H,
        LDR_LEN_L,
        LDR_DATA,
        LDR_CHK,
        LDR_RUN,
        LDR_ERR
    } ldr_state_t;

    localparam int REG_W = 32;
    localparam int INST_ADDR_W = 32;
    localparam int CNT_W = 16;

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Instruction word array: one synchronous write port, one combinational
// read port. Contents are not reset.
module inst_rom_loader_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [REG_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [REG_W-1:0]  rdata
);

    logic [REG_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction ROM filled from a byte stream while the CPU is held in reset.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_valid_i,
    input  logic [7:0]             ld_data_i,
    input  logic                   rom_ce_i,
    input  logic [INST_ADDR_W-1:0] rom_addr_i,
    output logic [REG_W-1:0]       rom_data_o,
    output logic                   cpu_rst_o,
    output logic                   ld_done_o,
    output logic                   ld_err_o
);

    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(2 ** ADDR_W);

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam ldr_state_t LOAD_END = LDR_CHK;
`else
    localparam ldr_state_t LOAD_END = LDR_RUN;
`endif

    ldr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d, idx_inc;
    logic [CNT_W-1:0] len_new;
    logic [1:0]       bc_q, bc_d;
    logic [23:0]      wbuf_q, wbuf_d;
    logic             mem_we;
    logic [REG_W-1:0] mem_rdata;
    logic             cpu_rst_q, done_q;
    logic             unused_addr_bits;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
    logic             err_q;
`endif

    assign idx_inc = idx_q + 16'd1;
    assign len_new = {cnt_q[15:8], ld_data_i};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bc_d    = bc_q;
        wbuf_d  = wbuf_q;
        mem_we  = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (ld_valid_i) begin
            unique case (state_q)
                LDR_IDLE: begin
                    if (ld_data_i == SYNC) state_d = LDR_LEN_H;
                end
                LDR_LEN_H: begin
                    cnt_d   = {ld_data_i, cnt_q[7:0]};
                    state_d = LDR_LEN_L;
                end
                LDR_LEN_L: begin
                    cnt_d   = len_new;
                    state_d = (len_new == '0) ? LOAD_END : LDR_DATA;
                end
                LDR_DATA: begin
                    bc_d   = bc_q + 2'd1;
                    wbuf_d = {wbuf_q[15:0], ld_data_i};
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ ld_data_i;
`endif
                    if (bc_q == 2'd3) begin
                        // out-of-range words are swallowed, never wrapped
                        mem_we = ({1'b0, idx_q} < DEPTH_L);
                        idx_d  = idx_inc;
                        if (idx_inc == cnt_q) state_d = LOAD_END;
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                LDR_CHK: begin
                    state_d = (ld_data_i == csum_q) ? LDR_RUN : LDR_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LDR_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            bc_q      <= '0;
            wbuf_q    <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            bc_q      <= bc_d;
            wbuf_q    <= wbuf_d;
            cpu_rst_q <= (state_q != LDR_RUN);
            done_q    <= (state_q == LDR_RUN);
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= (state_q == LDR_ERR);
        end
    end
    assign ld_err_o = err_q;
`else
    assign ld_err_o = 1'b0;
`endif

    inst_rom_loader_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_q[ADDR_W-1:0]),
        .wdata ({wbuf_q, ld_data_i}),
        .raddr (rom_addr_i[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    assign unused_addr_bits = ^{rom_addr_i[INST_ADDR_W-1:ADDR_W+2], rom_addr_i[1:0]};

    assign rom_data_o = rom_ce_i ? mem_rdata : '0;
    assign cpu_rst_o  = cpu_rst_q;
    assign ld_done_o  = done_q;

endmodule
